jericalla_sequencer: RTL and testbench
======================================

// Module: jericalla_sequencer
// PURPOSE
// Program sequencer for the jericalla ROM/ALU/RAM datapath. Fetches 17-bit
// instructions from a synchronous instruction memory starting at a base address
// and issues them to the datapath, one every two cycles.
// Captures each ALU result and reports completion with a one-cycle done pulse.
// Sits between the host/testbench control and the jericalla instr input.
// PARAMETERS
// PC_W     6   instruction-memory address width (program depth 2**PC_W)
// INSTR_W  17  instruction width {w_en, sel[3:0], addr1[3:0], addr2[3:0], waddr[3:0]}
// DATA_W   32  datapath result width
// PORTS
// clk          in   1         rising-edge clock
// rst_n        in   1         asynchronous, active-low reset
// start        in   1         run request; sampled only in IDLE
// base_addr    in   PC_W      first instruction address; sampled with start
// length       in   PC_W+1    instruction count, 0..2**PC_W; sampled with start
// abort        in   1         cancel current run
// imem_rd      out  1         instruction-memory read strobe
// imem_addr    out  PC_W      instruction-memory address
// imem_data    in   INSTR_W   read data, valid the cycle after imem_rd
// dp_valid     out  1         instruction on dp_instr is live this cycle
// dp_instr     out  INSTR_W   to datapath instr; all zeros when dp_valid=0
// dp_result    in   DATA_W    datapath result r (combinational from dp_instr)
// busy         out  1         state != IDLE
// done         out  1         one-cycle pulse at end of a completed run
// issued_count out  PC_W+1    instructions issued in the current/last run
// last_result  out  DATA_W    dp_result captured at the last issue
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; pc, issued_count, last_result = 0;
//   imem_rd, dp_valid, done, busy = 0; dp_instr = 0; imem_addr = 0.
// - States: IDLE, FETCH, ISSUE, DONE.
// - IDLE: start=1 & length!=0 -> FETCH; pc<=base_addr, len_q<=length,
//   issued_count<=0. start=1 & length==0 -> DONE, issued_count<=0, no fetch.
//   start ignored in every other state.
// - FETCH: imem_rd=1, imem_addr=pc; -> ISSUE unconditionally (unless abort).
// - ISSUE: dp_valid=1, dp_instr=imem_data (combinational pass-through);
//   at clock edge: last_result<=dp_result, issued_count++, pc<=pc+1 mod 2**PC_W.
//   If issued_count+1 == len_q -> DONE, else -> FETCH.
// - DONE: done=1 for exactly one cycle; -> IDLE. busy=1 in DONE.
// - Throughput: 2 cycles/instruction; run of N takes 2N+1 cycles start->done.
// - pc wrap: addresses wrap modulo 2**PC_W (base 62, PC_W=6, len 4 -> 62,63,0,1).
// - dp_instr forced to 0 whenever dp_valid=0, so datapath RAM w_en (bit 16)
//   is never asserted outside an ISSUE cycle.
// - abort=1 in FETCH or ISSUE: dp_valid and imem_rd masked to 0 that cycle,
//   dp_instr=0, no count/pc/last_result update; -> IDLE next edge, no done.
//   abort in IDLE or DONE has no effect (DONE still pulses).
// - Reset mid-run: immediate return to reset values; no done pulse.
// - issued_count and last_result hold their values in IDLE until next start.
// TESTING
// - Reset: rst_n low mid-ISSUE -> dp_valid, busy, done drop immediately;
//   counts 0.
// - Basic run: base=0, len=3, start at cycle 0 -> imem_rd cycles 1,3,5;
//   dp_valid cycles 2,4,6; done pulse cycle 7; issued_count=3;
//   last_result = result of 3rd instr.
// - Wrap: PC_W=6, base=62, len=4 -> imem_addr sequence 62,63,0,1; done at cycle 9.
// - Zero length: len=0 start -> done at cycle 1, imem_rd never asserted,
//   issued_count=0.
// - Abort: len=5, abort during 2nd ISSUE -> that dp_valid=0, dp_instr=0, IDLE
//   next cycle, no done, issued_count=1.
// - Start while busy: start pulse during run with base=10 -> ignored; run
//   completes with original base/len.

Source files
------------

// File: rtl/jericalla_sequencer_if.sv
// Control, instruction-memory and datapath signals of the jericalla sequencer.
// The slave modport is the sequencer's view; master is the host/memory/datapath side.
interface jericalla_sequencer_if #(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 17,
  parameter int DATA_W  = 32
);
  // Host control
  logic              start;
  logic [PC_W-1:0]   base_addr;
  logic [PC_W:0]     length;
  logic              abort;
  // Instruction memory (synchronous read, data one cycle after imem_rd)
  logic              imem_rd;
  logic [PC_W-1:0]   imem_addr;
  logic [INSTR_W-1:0] imem_data;
  // Datapath
  logic              dp_valid;
  logic [INSTR_W-1:0] dp_instr;
  logic [DATA_W-1:0] dp_result;
  // Status
  logic              busy;
  logic              done;
  logic [PC_W:0]     issued_count;
  logic [DATA_W-1:0] last_result;

  modport slave (
    input  start, base_addr, length, abort, imem_data, dp_result,
    output imem_rd, imem_addr, dp_valid, dp_instr, busy, done,
           issued_count, last_result
  );

  modport master (
    output start, base_addr, length, abort, imem_data, dp_result,
    input  imem_rd, imem_addr, dp_valid, dp_instr, busy, done,
           issued_count, last_result
  );
endinterface

// File: rtl/jericalla_sequencer.sv
// Program sequencer for the jericalla ROM/ALU/RAM datapath.
// Alternates FETCH (memory read) and ISSUE (instruction live on the datapath),
// so each instruction costs two cycles; a run of N ends with a done pulse.
module jericalla_sequencer #(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 17,
  parameter int DATA_W  = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  jericalla_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [PC_W:0]   CNT_ONE = (PC_W + 1)'(1);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W:0]      len_q, len_d;
  logic [PC_W:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]  result_q, result_d;

  logic               fetch_go;
  logic               issue_go;
  logic [PC_W:0]      cnt_inc;

  // An abort masks the memory strobe and the datapath issue in the same cycle.
  assign fetch_go = (state_q == FETCH) && !bus.abort;
  assign issue_go = (state_q == ISSUE) && !bus.abort;
  assign cnt_inc  = cnt_q + CNT_ONE;

  // Outputs decode straight from state so an async reset clears them at once.
  // dp_instr is held at zero outside a live issue so the RAM write enable
  // (instruction bit 16) can never fire spuriously.
  assign bus.imem_rd      = fetch_go;
  assign bus.imem_addr    = pc_q;
  assign bus.dp_valid     = issue_go;
  assign bus.dp_instr     = issue_go ? bus.imem_data : '0;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.issued_count = cnt_q;
  assign bus.last_result  = result_q;

  // State and run bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state and register-update decode.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        // Count and result survive in IDLE until the next accepted start.
        if (bus.start) begin
          cnt_d = '0;
          if (bus.length != '0) begin
            pc_d    = bus.base_addr;
            len_d   = bus.length;
            state_d = FETCH;
          end else begin
            // Empty program: report completion without touching memory.
            state_d = DONE;
          end
        end
      end

      FETCH: begin
        state_d = bus.abort ? IDLE : ISSUE;
      end

      ISSUE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          result_d = bus.dp_result;
          cnt_d    = cnt_inc;
          pc_d     = pc_q + PC_ONE;   // wraps modulo program depth
          state_d  = (cnt_inc == len_q) ? DONE : FETCH;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_jericalla_sequencer.sv
// Directed bench for jericalla_sequencer: synchronous instruction ROM model,
// combinational datapath model, and hand-sequenced runs with cycle-exact checks.
module tb_jericalla_sequencer;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 17;
  localparam int DATA_W  = 32;

  logic clk;
  logic rst_n;

  int n_assert = 0;
  int n_fail   = 0;

  logic [INSTR_W-1:0] imem [64];

  jericalla_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W)) bus ();

  jericalla_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: result depends on every instruction bit.
  function automatic logic [DATA_W-1:0] alu(input logic [INSTR_W-1:0] x);
    return {x[15:0], 16'h0000} ^ {15'h0000, x} ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous ROM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.imem_rd) bus.imem_data <= imem[bus.imem_addr];
  end

  assign bus.dp_result = alu(bus.dp_instr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full run with per-cycle checks; optionally pulses a second start mid-run.
  task automatic do_run(input int base, input int len, input bit poke_start);
    logic [PC_W-1:0] a;
    logic [PC_W-1:0] last_a;
    last_a = '0;
    bus.start     = 1'b1;
    bus.base_addr = PC_W'(base);
    bus.length    = (PC_W + 1)'(len);
    for (int k = 0; k < len; k++) begin
      a = PC_W'(base + k);
      tick();
      bus.start = 1'b0;
      chk("fetch_rd",    64'(bus.imem_rd),   64'd1);
      chk("fetch_addr",  64'(bus.imem_addr), 64'(a));
      chk("fetch_valid", 64'(bus.dp_valid),  64'd0);
      chk("fetch_busy",  64'(bus.busy),      64'd1);
      tick();
      bus.start = 1'b0;
      chk("issue_valid", 64'(bus.dp_valid),  64'd1);
      chk("issue_instr", 64'(bus.dp_instr),  64'(imem[a]));
      chk("issue_rd",    64'(bus.imem_rd),   64'd0);
      last_a = a;
      if (poke_start && k == 0) begin
        bus.start     = 1'b1;
        bus.base_addr = 6'd10;
        bus.length    = 7'd5;
      end
    end
    tick();
    bus.start = 1'b0;
    chk("done_pulse",  64'(bus.done),         64'd1);
    chk("done_busy",   64'(bus.busy),         64'd1);
    chk("done_count",  64'(bus.issued_count), 64'(len));
    chk("done_result", 64'(bus.last_result),  64'(alu(imem[last_a])));
    tick();
    chk("post_done",   64'(bus.done),         64'd0);
    chk("post_busy",   64'(bus.busy),         64'd0);
    chk("hold_count",  64'(bus.issued_count), 64'(len));
    $display("run base=%0d len=%0d issued=%0d last_result=%h",
             base, len, bus.issued_count, bus.last_result);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = INSTR_W'(i * 2643 + 4369);
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.abort     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_busy",   64'(bus.busy),         64'd0);
    chk("rst_done",   64'(bus.done),         64'd0);
    chk("rst_valid",  64'(bus.dp_valid),     64'd0);
    chk("rst_rd",     64'(bus.imem_rd),      64'd0);
    chk("rst_addr",   64'(bus.imem_addr),    64'd0);
    chk("rst_instr",  64'(bus.dp_instr),     64'd0);
    chk("rst_count",  64'(bus.issued_count), 64'd0);
    chk("rst_result", 64'(bus.last_result),  64'd0);
    rst_n = 1'b1;
    tick();
    $display("reset released");

    // Basic, start-while-busy, wrap
    do_run(0, 3, 1'b0);
    do_run(20, 2, 1'b1);
    do_run(62, 4, 1'b0);

    // Zero length, with abort asserted during DONE (no effect)
    bus.start     = 1'b1;
    bus.base_addr = 6'd7;
    bus.length    = 7'd0;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b1;
    #1;
    chk("zl_done",  64'(bus.done),         64'd1);
    chk("zl_rd",    64'(bus.imem_rd),      64'd0);
    chk("zl_count", 64'(bus.issued_count), 64'd0);
    chk("zl_busy",  64'(bus.busy),         64'd1);
    tick();
    bus.abort = 1'b0;
    chk("zl_post_done", 64'(bus.done), 64'd0);
    chk("zl_post_busy", 64'(bus.busy), 64'd0);
    $display("zero-length run issued=%0d", bus.issued_count);

    // Abort during FETCH
    bus.start     = 1'b1;
    bus.base_addr = 6'd40;
    bus.length    = 7'd2;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b1;
    #1;
    chk("abf_rd", 64'(bus.imem_rd), 64'd0);
    tick();
    bus.abort = 1'b0;
    chk("abf_busy",  64'(bus.busy),         64'd0);
    chk("abf_done",  64'(bus.done),         64'd0);
    chk("abf_count", 64'(bus.issued_count), 64'd0);
    $display("abort-in-fetch issued=%0d", bus.issued_count);

    // Abort during second ISSUE of a 5-instruction run
    bus.start     = 1'b1;
    bus.base_addr = 6'd5;
    bus.length    = 7'd5;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.abort = 1'b1;
    #1;
    chk("abi_valid", 64'(bus.dp_valid), 64'd0);
    chk("abi_instr", 64'(bus.dp_instr), 64'd0);
    tick();
    bus.abort = 1'b0;
    chk("abi_busy",   64'(bus.busy),         64'd0);
    chk("abi_done",   64'(bus.done),         64'd0);
    chk("abi_count",  64'(bus.issued_count), 64'd1);
    chk("abi_result", 64'(bus.last_result),  64'(alu(imem[5])));
    tick();
    chk("abi_no_done", 64'(bus.done), 64'd0);
    $display("abort-in-issue issued=%0d last_result=%h", bus.issued_count, bus.last_result);

    // Reset during second ISSUE of a run
    bus.start     = 1'b1;
    bus.base_addr = 6'd30;
    bus.length    = 7'd3;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_valid", 64'(bus.dp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid",  64'(bus.dp_valid),     64'd0);
    chk("mrst_busy",   64'(bus.busy),         64'd0);
    chk("mrst_done",   64'(bus.done),         64'd0);
    chk("mrst_instr",  64'(bus.dp_instr),     64'd0);
    chk("mrst_count",  64'(bus.issued_count), 64'd0);
    chk("mrst_result", 64'(bus.last_result),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_no_done", 64'(bus.done), 64'd0);
    chk("mrst_idle",    64'(bus.busy), 64'd0);
    $display("reset mid-run issued=%0d", bus.issued_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
